// File: rtl/game_pkg.sv
// Shared definitions for the volleyball game: rally FSM encodings and player ids.
// The physics and display blocks reuse the player constants.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_RALLY = 3'd2,
    ST_POINT = 3'd3,
    ST_PAUSE = 3'd4,
    ST_OVER  = 3'd5
  } state_e;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  // A landing on one side awards the point to the opposite player.
  function automatic logic scorer_of(input logic rise_left);
    return rise_left ? P2 : P1;
  endfunction

endpackage

// File: rtl/point_ctrl_rise_detect.sv
// Single-cycle rise detector for a level flag; the history register updates every cycle.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic rise
);

  logic in_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in;
    end
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/point_ctrl.sv
// Rally/point controller: turns floor-landing flags into score pulses and sequences
// serve, post-point pause and game-over. All outputs are decoded from registered state.
module point_ctrl
  import game_pkg::*;
#(
  parameter int unsigned PAUSE_CYCLES = 100_000_000,
  parameter int unsigned CNT_W        = $clog2(PAUSE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic land_left,
  input  logic land_right,
  input  logic carry_p1,
  input  logic carry_p2,
  output logic inc_p1,
  output logic inc_p2,
  output logic ball_reset,
  output logic serve_right,
  output logic freeze,
  output logic game_over,
  output logic winner_right
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             scorer_q, scorer_d;
  logic             serve_q, serve_d;
  logic             winner_q, winner_d;
  logic             rise_left, rise_right;
  logic             scorer_carry;

  rise_detect u_rise_left (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (land_left),
    .rise  (rise_left)
  );

  rise_detect u_rise_right (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (land_right),
    .rise  (rise_right)
  );

  assign scorer_carry = (scorer_q == P2) ? carry_p2 : carry_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      scorer_q <= P1;
      serve_q  <= P1;
      winner_q <= P1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      scorer_q <= scorer_d;
      serve_q  <= serve_d;
      winner_q <= winner_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    scorer_d = scorer_q;
    serve_d  = serve_q;
    winner_d = winner_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SERVE;
          serve_d = P1;
        end
      end
      ST_SERVE: state_d = ST_RALLY;
      ST_RALLY: begin
        // Simultaneous rises on both sides are an ambiguous landing and are dropped.
        if (rise_left ^ rise_right) begin
          state_d  = ST_POINT;
          scorer_d = scorer_of(rise_left);
        end
      end
      ST_POINT: begin
        serve_d = scorer_q;
        if (scorer_carry) begin
          state_d  = ST_OVER;
          winner_d = scorer_q;
        end else begin
          state_d = ST_PAUSE;
          cnt_d   = CNT_W'(PAUSE_CYCLES - 1);
        end
      end
      ST_PAUSE: begin
        if (cnt_q == '0) begin
          state_d = ST_SERVE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_OVER: begin
        if (start) begin
          state_d  = ST_SERVE;
          serve_d  = ~winner_q;
          winner_d = P1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    inc_p1       = (state_q == ST_POINT) && (scorer_q == P1);
    inc_p2       = (state_q == ST_POINT) && (scorer_q == P2);
    ball_reset   = (state_q == ST_SERVE);
    freeze       = (state_q != ST_SERVE) && (state_q != ST_RALLY);
    game_over    = (state_q == ST_OVER);
    serve_right  = serve_q;
    winner_right = winner_q;
  end

endmodule

// File: tb/tb_point_ctrl.sv
// Directed bench for point_ctrl with PAUSE_CYCLES=4 and two behavioural
// score counters (limit 3, reset value 1) closing the carry loop.
module tb_point_ctrl;

  localparam int unsigned PAUSE_CYCLES = 4;
  localparam logic [1:0]  LIMIT        = 2'd3;

  logic clk = 1'b0;
  logic rst_n, start, land_left, land_right;
  logic carry_p1, carry_p2;
  logic inc_p1, inc_p2, ball_reset, serve_right, freeze, game_over, winner_right;
  logic [1:0] val_p1, val_p2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  point_ctrl #(.PAUSE_CYCLES(PAUSE_CYCLES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .land_left    (land_left),
    .land_right   (land_right),
    .carry_p1     (carry_p1),
    .carry_p2     (carry_p2),
    .inc_p1       (inc_p1),
    .inc_p2       (inc_p2),
    .ball_reset   (ball_reset),
    .serve_right  (serve_right),
    .freeze       (freeze),
    .game_over    (game_over),
    .winner_right (winner_right)
  );

  // Score counters: count 1..LIMIT and wrap to 1, carry while at limit and incremented.
  assign carry_p1 = (val_p1 == LIMIT) && inc_p1;
  assign carry_p2 = (val_p2 == LIMIT) && inc_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_p1 <= 2'd1;
      val_p2 <= 2'd1;
    end else begin
      if (inc_p1) val_p1 <= (val_p1 == LIMIT) ? 2'd1 : val_p1 + 2'd1;
      if (inc_p2) val_p2 <= (val_p2 == LIMIT) ? 2'd1 : val_p2 + 2'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ball_reset(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (ball_reset === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; land_left = 1'b0; land_right = 1'b0;

    // 1. reset state, then start -> serve
    tick(); tick();
    check("rst_freeze", 32'(freeze), 32'd1);
    check("rst_others", {inc_p1, inc_p2, ball_reset, serve_right, game_over, winner_right}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_hold", {freeze, ball_reset}, 32'b10);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ball_reset", {ball_reset, serve_right, freeze}, 32'b100);
    tick();
    check("rally_entry", {ball_reset, freeze}, 32'b00);

    // 2. land_right rise -> P1 point, pause, serve by P1
    land_right = 1'b1;
    tick();
    check("p1_point_inc", {inc_p1, inc_p2, freeze}, 32'b101);
    check("p1_val_before", 32'(val_p1), 32'd1);
    land_right = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("p1_pause_%0d", i), {freeze, inc_p1, ball_reset}, 32'b100);
    end
    check("p1_val_after", 32'(val_p1), 32'd2);
    tick();
    check("p1_serve", {ball_reset, serve_right, freeze}, 32'b100);
    tick();

    // 3. land_left held across POINT/PAUSE gives one point only
    land_left = 1'b1;
    tick();
    check("p2_point_inc", {inc_p1, inc_p2}, 32'b01);
    tick();
    check("p2_serve_side", 32'(serve_right), 32'd1);
    wait_ball_reset("p2_ball_reset", 10);
    check("p2_serve_right", 32'(serve_right), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("held_no_inc_%0d", i), {inc_p2, freeze}, 32'b00);
    end
    check("held_val_p2", 32'(val_p2), 32'd2);
    land_left = 1'b0;
    tick();
    land_left = 1'b1;
    tick();
    check("rerise_inc_p2", {inc_p1, inc_p2}, 32'b01);
    land_left = 1'b0;
    tick();
    check("rerise_val_p2", 32'(val_p2), 32'd3);
    wait_ball_reset("rerise_ball_reset", 10);
    check("rerise_serve_right", 32'(serve_right), 32'd1);
    tick();

    // 4. simultaneous rises ignored, then a single rise scores
    land_left = 1'b1; land_right = 1'b1;
    tick();
    check("both_no_point", {inc_p1, inc_p2, freeze, ball_reset}, 32'b0000);
    tick();
    check("both_stay", {inc_p1, inc_p2, freeze}, 32'b000);
    land_right = 1'b0;
    tick();
    land_right = 1'b1;
    tick();
    check("single_after_both", {inc_p1, inc_p2, freeze}, 32'b101);
    land_left = 1'b0; land_right = 1'b0;
    wait_ball_reset("single_ball_reset", 10);
    check("single_serve_right", 32'(serve_right), 32'd0);
    check("single_val_p1", 32'(val_p1), 32'd3);
    tick();

    // 5. P2 at limit scores -> carry, game over, P2 wins; start serves from loser
    land_left = 1'b1;
    tick();
    check("final_inc_carry", {inc_p2, carry_p2, carry_p1}, 32'b110);
    tick();
    check("over_flags", {game_over, winner_right, freeze, serve_right}, 32'b1111);
    check("over_wrap_p2", 32'(val_p2), 32'd1);
    land_left = 1'b0;
    tick();
    land_left = 1'b1;
    tick();
    check("over_ignore_land", {game_over, inc_p1, inc_p2}, 32'b100);
    land_left = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_serve", {ball_reset, serve_right, game_over, winner_right}, 32'b1000);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ignored_rally", {ball_reset, freeze}, 32'b00);

    // 6. reset mid-PAUSE drops the pending serve; land before start is ignored
    land_left = 1'b1;
    tick();
    check("pre_rst_inc_p2", 32'(inc_p2), 32'd1);
    land_left = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_pause", {freeze, ball_reset, serve_right, game_over, winner_right}, 32'b10000);
    tick();
    rst_n = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (ball_reset === 1'b1) seen = 1'b1;
      end
      check("no_ball_reset_after_rst", 32'(seen), 32'd0);
    end
    land_right = 1'b1;
    tick();
    check("idle_land_no_inc", {inc_p1, inc_p2, freeze}, 32'b001);
    tick();
    check("idle_land_stay", {inc_p1, inc_p2, freeze}, 32'b001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/point_ctrl.md
# point_ctrl

Rally/point controller for the two-player volleyball game. Sits directly upstream of the two per-player score `upcounter` instances. It turns level-type ball-landing flags from the physics block into single-cycle `increase` pulses, one per point. It consumes each counter's `carry` to detect match end, and sequences serve, post-point pause and game-over for the physics and display logic.

## Interface
Parameters:
- PAUSE_CYCLES, default 100_000_000: post-point freeze length in clk cycles (≥1); 1 s at 100 MHz.
- CNT_W, default $clog2(PAUSE_CYCLES+1): pause counter width.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse from the debounced/one-pulsed start button.
- land_left  in  1  level; ball touching floor on the left (P1) side.
- land_right  in  1  level; ball touching floor on the right (P2) side.
- carry_p1  in  1  `carry` of the P1 score counter.
- carry_p2  in  1  `carry` of the P2 score counter.
- inc_p1  out  1  drives `increase` of the P1 counter.
- inc_p2  out  1  drives `increase` of the P2 counter.
- ball_reset  out  1  one-cycle pulse; physics places the ball at the server.
- serve_right  out  1  0 = P1 (left) serves, 1 = P2 (right) serves.
- freeze  out  1  physics/player motion halted.
- game_over  out  1  match finished.
- winner_right  out  1  valid while game_over; 1 = P2 won.

## Operation
- The FSM has states IDLE, SERVE, RALLY, POINT, PAUSE and OVER.
- All outputs are decoded from registered state only (Moore). There is no combinational path from any input to any output.
- Rise detection: `land_x & ~land_x_q`. The `land_x_q` registers update every cycle in every state.
- Scoring map: a land_left rise gives P2 the point. A land_right rise gives P1 the point.
- IDLE: freeze=1. On start → SERVE with serve_right=0.
- SERVE: lasts 1 cycle. ball_reset=1, freeze=0. Always → RALLY.
- RALLY: freeze=0.
  - Exactly one rise → POINT; the scorer is latched.
  - Both rise in the same cycle → ignored; stay in RALLY.
  - No rise → stay.
- POINT: lasts 1 cycle. The scorer's inc_pX=1 and freeze=1. The scorer's carry_pX is sampled this cycle.
  - carry=1 → OVER, with winner_right=scorer.
  - carry=0 → PAUSE, with the pause counter loaded to PAUSE_CYCLES-1.
  - In both cases serve_right is set to the scorer.
- PAUSE: freeze=1. The counter decrements each cycle; at 0 → SERVE.
- OVER: freeze=1, game_over=1. On start → SERVE, with serve_right set to the loser and winner_right cleared.
  - The counters have already wrapped to 1 on carry, so no counter reset is needed.
- start outside IDLE/OVER is ignored. Land rises outside RALLY are ignored and never queued.
- A land level held high from a previous point produces no point in RALLY. The flag must fall and rise again.
- Reset values: state=IDLE, freeze=1, and all other outputs 0, including serve_right=0 and winner_right=0. The pause counter and edge registers are also 0.
- Reset asserted mid-operation (any state) → IDLE immediately. Any pending ball_reset or inc pulse is lost.

## Timing
- A rise sampled at edge N puts the FSM in POINT for cycle N..N+1. inc_pX is high for exactly that one cycle.
- The counter updates at edge N+1.
- inc_p1 and inc_p2 are never high together. Each is high for at most 1 cycle per point.
- Point → ball_reset: 1 (POINT) + PAUSE_CYCLES cycles. ball_reset is high for 1 cycle, then RALLY begins.
- start → ball_reset asserted in the very next cycle.
- carry is combinational in the counter (value==limit && increase). It is valid only during POINT and is ignored in all other states.

## Structure
- Shared package/header `game_pkg`:
  - state encodings (3 bits);
  - player constants P1=0, P2=1.
  - The physics and display blocks reuse the player constants.
- One sub-module, `rise_detect` (clk, rst_n, in, rise), instantiated for land_left and land_right.
- All other logic is flat: state register, pause counter, scorer/serve/winner registers and output decode.

## Test plan
The bench uses PAUSE_CYCLES=4 and two real upcounters with limit=3 (values reset to 1).

1. Reset, then start → freeze=1, others 0, during reset. ball_reset appears 1 cycle after start with serve_right=0. freeze drops.
2. land_right rise in RALLY → inc_p1 high 1 cycle and P1 value 1→2. freeze is high for 5 cycles. ball_reset arrives 5 cycles after POINT with serve_right=0.
3. land_left held high through POINT and PAUSE into RALLY → no second inc. Drop it and raise it again → inc_p2 fires, and serve_right=1 for the next serve.
4. land_left and land_right rise in the same RALLY cycle → no inc and no state change. A later single rise scores normally.
5. P2 at value 3 scores → carry_p2=1 in POINT, then game_over=1 and winner_right=1, and P2 value wraps to 1. start → SERVE with serve_right=0 and game_over=0.
6. rst_n pulsed low mid-PAUSE (count 2) → IDLE immediately, and no ball_reset follows. A land rise before start produces no inc.
